// File: rtl/sw_debounce_pkg.sv
// Shared types for the switch debouncer: FSM state encoding and synchroniser depth.
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } sw_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sw_debounce_pulse_if.sv
// Switch pin and conditioned outputs of one debouncer instance.
interface sw_debounce_pulse_if;

    logic i_sw;
    logic o_sw_level;
    logic o_press_pulse;
    logic o_release_pulse;

    modport master (
        output i_sw,
        input  o_sw_level,
        input  o_press_pulse,
        input  o_release_pulse
    );

    modport slave (
        input  i_sw,
        output o_sw_level,
        output o_press_pulse,
        output o_release_pulse
    );

endinterface

// File: rtl/sw_debounce_pulse_sync.sv
// sw_sync: multi-flop synchroniser that also normalises pin polarity (1 = pressed).
module sw_sync
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STAGES      = SYNC_STAGES,
    parameter int          ACTIVE_HIGH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic              w_norm;
    logic [STAGES-1:0] r_sync;

    assign w_norm = (ACTIVE_HIGH != 0) ? i_async : ~i_async;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], w_norm};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/sw_debounce_pulse.sv
// sw_debounce_pulse: synchronise, debounce and edge-detect one mechanical switch.
// Define SW_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module sw_debounce_pulse
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int          ACTIVE_HIGH     = 1,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    sw_debounce_pulse_if.slave  sw_if
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("sw_debounce_pulse: parameter out of legal range");
    end

`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned      REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned      REP_W     = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
`endif

    logic             w_sync_q;
    sw_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    sw_sync #(
        .STAGES      (SYNC_STAGES),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (sw_if.i_sw),
        .o_sync  (w_sync_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                    if (w_sync_q) r_state <= S_PRESS_WAIT;
                end
                S_PRESS_WAIT: begin
                    if (!w_sync_q) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    r_level <= 1'b1;
                    if (!w_sync_q) begin
                        r_state <= S_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
                    // Repeat counter pauses in S_RELEASE_WAIT so a bounce resumes, not restarts, it.
                    else if (r_rep_cnt == (r_rep_armed ? REP_NEXT : REP_FIRST)) begin
                        r_press     <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_rep_armed <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
`endif
                end
                S_RELEASE_WAIT: begin
                    if (w_sync_q) begin
                        r_state <= S_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
                        r_rep_cnt   <= '0;
                        r_rep_armed <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign sw_if.o_sw_level      = r_level;
    assign sw_if.o_press_pulse   = r_press;
    assign sw_if.o_release_pulse = r_release;

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Scoreboard bench for sw_debounce_pulse: expected pulse cycles queued at stimulus time.
module tb_sw_debounce_pulse;
    import sw_debounce_pkg::*;

    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = DB + 3;

    typedef struct packed {
        logic [1:0]  dut;
        logic        rel;
        int unsigned cyc;
    } ev_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sw_debounce_pulse_if if_a ();
    sw_debounce_pulse_if if_b ();
    sw_debounce_pulse_if if_c ();

    sw_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .ACTIVE_HIGH(1), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_a));
    sw_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .ACTIVE_HIGH(0), .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_b));
    sw_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .ACTIVE_HIGH(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
        dut_c (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_c));

    function automatic ev_t mk(input int unsigned d, input logic r, input int unsigned c);
        ev_t e;
        e.dut = d[1:0];
        e.rel = r;
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (if_a.o_press_pulse)   obs_q.push_back(mk(0, 1'b0, cyc));
        if (if_a.o_release_pulse) obs_q.push_back(mk(0, 1'b1, cyc));
        if (if_b.o_press_pulse)   obs_q.push_back(mk(1, 1'b0, cyc));
        if (if_b.o_release_pulse) obs_q.push_back(mk(1, 1'b1, cyc));
        if (if_c.o_press_pulse)   obs_q.push_back(mk(2, 1'b0, cyc));
        if (if_c.o_release_pulse) obs_q.push_back(mk(2, 1'b1, cyc));
    end

    task automatic wait_neg(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        if_a.i_sw = 1'b1;
        if_b.i_sw = 1'b0;
        if_c.i_sw = 1'b0;
        rst_n = 1'b0;
        wait_neg(3);
        tests++;
        if ({if_a.o_sw_level, if_a.o_press_pulse, if_a.o_release_pulse,
             if_b.o_sw_level, if_b.o_press_pulse, if_b.o_release_pulse} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs a=%b%b%b b=%b%b%b expected 000000", if_a.o_sw_level,
                     if_a.o_press_pulse, if_a.o_release_pulse, if_b.o_sw_level, if_b.o_press_pulse,
                     if_b.o_release_pulse);
        end
        tests++;
        if (dut_a.r_state !== S_IDLE || dut_a.r_cnt !== '0) begin
            fails++;
            $display("FAIL reset_state state=%0d cnt=%0d expected 0/0", dut_a.r_state, dut_a.r_cnt);
        end
        if_a.i_sw = 1'b0;
        if_b.i_sw = 1'b1;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(12);
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_no_events got %0d events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_clean_press();
        ev_t e, o;
        exp_q.push_back(mk(0, 1'b0, cyc + LAT));
        if_a.i_sw = 1'b1;
        wait_neg(LAT - 1);
        tests++;
        if (if_a.o_sw_level !== 1'b0) begin
            fails++;
            $display("FAIL press_level_early level=%b expected 0", if_a.o_sw_level);
        end
        wait_neg(1);
        tests++;
        if (if_a.o_sw_level !== 1'b1 || if_a.o_press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL press_edge level=%b pulse=%b expected 1/1", if_a.o_sw_level, if_a.o_press_pulse);
        end
        wait_neg(1);
        tests++;
        if (if_a.o_press_pulse !== 1'b0 || if_a.o_sw_level !== 1'b1) begin
            fails++;
            $display("FAIL press_single_cycle pulse=%b level=%b expected 0/1", if_a.o_press_pulse, if_a.o_sw_level);
        end
        wait_neg(12);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL press_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL press_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_release_glitch();
        ev_t e, o;
        if_a.i_sw = 1'b0;
        wait_neg(2);
        if_a.i_sw = 1'b1;
        wait_neg(12);
        tests++;
        if (if_a.o_sw_level !== 1'b1 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL release_glitch level=%b events=%0d expected 1/0", if_a.o_sw_level, obs_q.size());
        end
        obs_q.delete();
        exp_q.push_back(mk(0, 1'b1, cyc + LAT));
        if_a.i_sw = 1'b0;
        wait_neg(LAT - 1);
        tests++;
        if (if_a.o_sw_level !== 1'b1) begin
            fails++;
            $display("FAIL release_level_early level=%b expected 1", if_a.o_sw_level);
        end
        wait_neg(1);
        tests++;
        if (if_a.o_sw_level !== 1'b0 || if_a.o_release_pulse !== 1'b1) begin
            fails++;
            $display("FAIL release_edge level=%b pulse=%b expected 0/1", if_a.o_sw_level, if_a.o_release_pulse);
        end
        wait_neg(10);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL release_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL release_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_press_glitch();
        for (int unsigned w = DB - 1; w <= DB; w++) begin
            if_a.i_sw = 1'b1;
            wait_neg(w);
            if_a.i_sw = 1'b0;
            wait_neg(12);
            tests++;
            if (if_a.o_sw_level !== 1'b0 || dut_a.r_state !== S_IDLE || obs_q.size() != 0) begin
                fails++;
                $display("FAIL press_glitch_w%0d level=%b state=%0d events=%0d expected 0/0/0",
                         w, if_a.o_sw_level, dut_a.r_state, obs_q.size());
            end
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        int unsigned c0;
        c0 = cyc;
        exp_q.push_back(mk(0, 1'b0, c0 + LAT));
        exp_q.push_back(mk(0, 1'b1, c0 + DB + 1 + LAT));
        if_a.i_sw = 1'b1;
        wait_neg(DB + 1);
        if_a.i_sw = 1'b0;
        wait_neg(20);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_active_low();
        ev_t e, o;
        exp_q.push_back(mk(1, 1'b0, cyc + LAT));
        if_b.i_sw = 1'b0;
        wait_neg(LAT - 1);
        tests++;
        if (if_b.o_sw_level !== 1'b0) begin
            fails++;
            $display("FAIL al_level_early level=%b expected 0", if_b.o_sw_level);
        end
        wait_neg(1);
        tests++;
        if (if_b.o_sw_level !== 1'b1 || if_b.o_press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL al_press level=%b pulse=%b expected 1/1", if_b.o_sw_level, if_b.o_press_pulse);
        end
        wait_neg(13);
        exp_q.push_back(mk(1, 1'b1, cyc + LAT));
        if_b.i_sw = 1'b1;
        wait_neg(LAT);
        tests++;
        if (if_b.o_sw_level !== 1'b0 || if_b.o_release_pulse !== 1'b1) begin
            fails++;
            $display("FAIL al_release level=%b pulse=%b expected 0/1", if_b.o_sw_level, if_b.o_release_pulse);
        end
        wait_neg(5);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL al_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL al_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        if_a.i_sw = 1'b1;
        wait_neg(5);
        tests++;
        if (dut_a.r_state !== S_PRESS_WAIT || dut_a.r_cnt !== 2'd2) begin
            fails++;
            $display("FAIL mid_pre_state state=%0d cnt=%0d expected 1/2", dut_a.r_state, dut_a.r_cnt);
        end
        rst_n = 1'b0;
        wait_neg(1);
        tests++;
        if (dut_a.r_state !== S_IDLE || if_a.o_sw_level !== 1'b0) begin
            fails++;
            $display("FAIL mid_in_reset state=%0d level=%b expected 0/0", dut_a.r_state, if_a.o_sw_level);
        end
        wait_neg(3);
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 1'b0, cyc + LAT));
        wait_neg(LAT - 1);
        tests++;
        if (if_a.o_sw_level !== 1'b0) begin
            fails++;
            $display("FAIL mid_level_early level=%b expected 0", if_a.o_sw_level);
        end
        wait_neg(6);
        exp_q.push_back(mk(0, 1'b1, cyc + LAT));
        if_a.i_sw = 1'b0;
        wait_neg(12);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL mid_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_hold_repeat();
        ev_t e, o;
        int unsigned c0;
        c0 = cyc;
        exp_q.push_back(mk(2, 1'b0, c0 + LAT));
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
        // Last sample seen pressed is at c0+42, so repeats land at +17..+42 in steps of 5.
        for (int unsigned j = 0; j < 6; j++) exp_q.push_back(mk(2, 1'b0, c0 + LAT + 10 + 5 * j));
`endif
        exp_q.push_back(mk(2, 1'b1, c0 + 40 + LAT));
        if_c.i_sw = 1'b1;
        wait_neg(40);
        if_c.i_sw = 1'b0;
        wait_neg(15);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL hold_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL hold_event got dut%0d rel=%b cyc=%0d expected dut%0d rel=%b cyc=%0d",
                         o.dut, o.rel, o.cyc, e.dut, e.rel, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        if_a.i_sw = 1'b0;
        if_b.i_sw = 1'b1;
        if_c.i_sw = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_release_glitch();
        test_press_glitch();
        test_back_to_back();
        test_active_low();
        test_reset_mid();
        test_hold_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
